// File: rtl/btn_report.sv
// btn_report: 16-button synchroniser + debouncer publishing state/change report strobes.
// Latency: 2 clk synchroniser + DEB_TICKS prescaler ticks; the report is registered on the commit edge.
// Backpressure: none; btn_rpt_stb is a one-cycle pulse the consumer must sample.
// Optional: define BTN_REPEAT_EN to auto-repeat held REPEAT_MASK buttons.
module btn_report #(
    parameter int unsigned TICK_DIV     = 12000,
    parameter int unsigned DEB_TICKS    = 8,
    parameter int unsigned REPEAT_DELAY = 40,
    parameter int unsigned REPEAT_RATE  = 10,
    parameter logic [15:0] REPEAT_MASK  = 16'h001F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] btn_raw,
    output logic [15:0] btn_rpt_state,
    output logic [15:0] btn_rpt_change,
    output logic        btn_rpt_stb
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic [15:0]   sync1;
    logic [15:0]   sync2;
    logic [PW-1:0] pre;
    logic          tick;
    logic [15:0]   stable;
    logic [CW-1:0] cnt [16];
    logic [15:0]   commit;
    logic          rpt_fire;
    logic [15:0]   rpt_mask;

    // Two-flop synchroniser per button; raw levels may be asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Free-running prescaler; tick marks the last count of each period.
    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // A bit commits when it disagrees with stable on the DEB_TICKS-th consecutive tick.
    always_comb begin
        commit = '0;
        for (int i = 0; i < 16; i++) begin
            commit[i] = tick && (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Per-bit disagreement counters and the committed stable state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            stable <= stable ^ commit;
            for (int i = 0; i < 16; i++) begin
                if (sync2[i] == stable[i] || commit[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_next;
    logic          rep_first;
    logic          rep_due;
    logic [15:0]   held;

    assign held     = stable & REPEAT_MASK;
    assign rep_next = rep_cnt + 1'b1;
    // A commit on the same tick suppresses the repeat; the first gap is DELAY, later ones RATE.
    assign rep_due  = tick && (commit == '0) && (held != '0) &&
                      (rep_next == (rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));

    // Repeat tick counter: restarts on any commit or when no eligible button is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (tick) begin
            if (commit != '0 || held == '0) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (rep_due) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt   <= rep_next;
            end
        end
    end

    assign rpt_fire = (commit != '0) || rep_due;
    assign rpt_mask = (commit != '0) ? commit : held;
`else
    logic rep_cfg_unused;
    assign rep_cfg_unused = ^{REPEAT_MASK, 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};

    assign rpt_fire = (commit != '0);
    assign rpt_mask = commit;
`endif

    // Report registers: strobe for one cycle, change mask held until the next strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_rpt_stb    <= 1'b0;
            btn_rpt_change <= '0;
        end else begin
            btn_rpt_stb <= rpt_fire;
            if (rpt_fire) begin
                btn_rpt_change <= rpt_mask;
            end
        end
    end

    assign btn_rpt_state = stable;

endmodule

// File: tb/tb_btn_report.sv
// Testbench for btn_report: directed button scenarios with literal expectations,
// plus a tick-level behavioural model compared against the outputs every cycle.
`timescale 1ns/1ps
module tb_btn_report;

    localparam int          TD = 4;
    localparam int          DT = 3;
    localparam int          RD = 5;
    localparam int          RR = 2;
    localparam logic [15:0] RM = 16'h001F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] btn_raw = '0;
    logic [15:0] st;
    logic [15:0] ch;
    logic        stb;

    always #5 clk = ~clk;

    btn_report #(
        .TICK_DIV(TD), .DEB_TICKS(DT), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .REPEAT_MASK(RM)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_rpt_state(st), .btn_rpt_change(ch), .btn_rpt_stb(stb)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Sync = raw two edges back; ticks every TD edges after reset; a bit commits after
    // DT consecutive disagreeing ticks; repeats when held ticks hit RD, RD+RR, RD+2RR...
    logic [15:0] m_d1 = '0, m_d2 = '0, m_stable = '0, m_change = '0;
    logic        m_stb = 1'b0;
    int          m_cyc = 0;
    int          m_run [16];
    int          m_held = 0;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        logic [15:0] s;
        logic [15:0] com;
        bit          tk;
        bit          rep;
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_stable = '0; m_change = '0; m_stb = 1'b0;
            m_cyc = 0; m_held = 0;
            for (int i = 0; i < 16; i++) m_run[i] = 0;
        end else begin
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = btn_raw;
            tk   = (m_cyc % TD) == TD - 1;
            m_cyc++;
            com  = '0;
            rep  = 1'b0;
            if (tk) begin
                for (int i = 0; i < 16; i++) begin
                    if (s[i] != m_stable[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DT) begin
                            com[i]   = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_stable = m_stable ^ com;
`ifdef BTN_REPEAT_EN
                if (com != '0 || (m_stable & RM) == '0) m_held = 0;
                else begin
                    m_held++;
                    rep = (m_held >= RD) && ((m_held - RD) % RR == 0);
                end
`endif
            end
            m_stb = (com != '0) || rep;
            if (com != '0) m_change = com;
            else if (rep) m_change = m_stable & RM;
        end
        m_live = 1'b1;
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            checks++;
            if (st === m_stable && ch === m_change && stb === m_stb) passes++;
            else $display("FAIL model t=%0t: state %h/%h change %h/%h stb %b/%b (got/expected)",
                          $time, st, m_stable, ch, m_change, stb, m_stb);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_stb(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (stb === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic count_stb(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (stb === 1'b1) c++;
        end
    endtask

    // Waits through any repeat strobes until the release report arrives.
    task automatic wait_release(output bit ok);
        int n;
        bit got;
        ok = 1'b0;
        for (int k = 0; k < 6 && !ok; k++) begin
            wait_stb(30, n, got);
            if (got && st === 16'h0000) ok = 1'b1;
        end
    endtask

    initial begin
        int n;
        int c;
        bit ok;

        rst = 1'b1; btn_raw = '0;
        cyc(3);
        check("reset_state", st, 32'h0);
        check("reset_change", ch, 32'h0);
        check("reset_stb", stb, 32'h0);
        rst = 1'b0;

        count_stb(100, c);
        check("idle_stb_count", c, 32'd0);
        check("idle_state", st, 32'h0);

        // single press / release of bit 0
        btn_raw = 16'h0001;
        wait_stb(30, n, ok);
        check("press0_seen", ok, 32'd1);
        check("press0_latency_in_range", (n >= 11 && n <= 18), 32'd1);
        check("press0_state", st, 32'h0001);
        check("press0_change", ch, 32'h0001);
        btn_raw = 16'h0000;
        wait_stb(30, n, ok);
        check("release0_seen", ok, 32'd1);
        check("release0_state", st, 32'h0000);
        check("release0_change", ch, 32'h0001);

        // 6-clk glitch on bit 5 must never commit
        btn_raw = 16'h0020;
        cyc(6);
        btn_raw = 16'h0000;
        count_stb(40, c);
        check("glitch_stb_count", c, 32'd0);
        check("glitch_state", st, 32'h0000);

        // bits 1 and 9 together merge into one strobe
        btn_raw = 16'h0202;
        wait_stb(30, n, ok);
        check("pair_seen", ok, 32'd1);
        check("pair_state", st, 32'h0202);
        check("pair_change", ch, 32'h0202);
        btn_raw = 16'h0000;
        wait_stb(30, n, ok);
        check("pair_release_state", st, 32'h0000);
        check("pair_release_change", ch, 32'h0202);

        // reset in the middle of a bit-3 debounce
        btn_raw = 16'h1000;
        wait_stb(30, n, ok);
        check("b12_state", st, 32'h1000);
        btn_raw = 16'h1008;
        cyc(10);
        rst = 1'b1;
        cyc(1);
        check("midrst_state", st, 32'h0);
        check("midrst_change", ch, 32'h0);
        check("midrst_stb", stb, 32'h0);
        rst = 1'b0;
        wait_stb(30, n, ok);
        check("postrst_latency", n, 32'd12);
        check("postrst_state", st, 32'h1008);
        check("postrst_change", ch, 32'h1008);
        btn_raw = 16'h0000;
        wait_release(ok);
        check("postrst_release", ok, 32'd1);

        // bit 2 held: auto-repeat only when enabled
        btn_raw = 16'h0004;
        wait_stb(30, n, ok);
        check("b2_press_state", st, 32'h0004);
`ifdef BTN_REPEAT_EN
        wait_stb(40, n, ok);
        check("rep_first_gap", n, 32'd20);
        check("rep_first_change", ch, 32'h0004);
        check("rep_first_state", st, 32'h0004);
        wait_stb(20, n, ok);
        check("rep_second_gap", n, 32'd8);
        check("rep_second_change", ch, 32'h0004);
        btn_raw = 16'h0000;
        wait_release(ok);
        check("b2_release", ok, 32'd1);

        // bit 8 is not eligible for repeat
        btn_raw = 16'h0100;
        wait_stb(30, n, ok);
        check("b8_press_state", st, 32'h0100);
        count_stb(40, c);
        check("b8_no_repeat", c, 32'd0);
        btn_raw = 16'h0000;
        wait_stb(30, n, ok);
        check("b8_release_state", st, 32'h0000);
`else
        count_stb(40, c);
        check("b2_no_repeat", c, 32'd0);
        btn_raw = 16'h0000;
        wait_stb(30, n, ok);
        check("b2_release_state", st, 32'h0000);
        check("b2_release_change", ch, 32'h0004);
`endif
        cyc(4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
